// File: rtl/rv_pkg.sv
// Shared defaults and clear-sequencer state type for the multi-port register file.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

endpackage

// File: rtl/rv_regfile_clr_seq.sv
// Clear sequencer: walks every entry once after reset, writing zero, then reports ready.
module rv_regfile_clr_seq
  import rv_pkg::*;
#(
  parameter int unsigned  NREGS = NREGS_DEFAULT,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          ready_o
);

  rf_state_e     r_state;
  rf_state_e     w_state_next;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    clr_we_o     = 1'b0;
    ready_o      = 1'b0;
    unique case (r_state)
      RF_CLEAR: begin
        clr_we_o   = 1'b1;
        w_cnt_next = r_cnt + AW'(1);
        if (r_cnt == AW'(NREGS - 1)) begin
          w_state_next = RF_READY;
          w_cnt_next   = '0;
        end
      end
      RF_READY: ready_o = 1'b1;
      default:  w_state_next = RF_CLEAR;
    endcase
  end

  assign clr_addr_o = r_cnt;

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-port integer register file with hardware clear, optional write->read bypass and
// optional registered read data.
module rv_regfile_mp
  import rv_pkg::*;
#(
  parameter int unsigned  XLEN     = XLEN_DEFAULT,
  parameter int unsigned  NREGS    = NREGS_DEFAULT,
  parameter int unsigned  NUM_RD   = 2,
  parameter int unsigned  NUM_WR   = 1,
  parameter int unsigned  ZERO_R0  = 1,
  parameter int unsigned  BYPASS   = 1,
  parameter int unsigned  READ_REG = 0,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   ready_o,
  input  logic [NUM_WR-1:0]      we_i,
  input  logic [NUM_WR*AW-1:0]   waddr_i,
  input  logic [NUM_WR*XLEN-1:0] wdata_i,
  input  logic [NUM_RD*AW-1:0]   raddr_i,
  output logic [NUM_RD*XLEN-1:0] rdata_o
);

  logic [XLEN-1:0]        r_mem [NREGS];
  logic                   w_clr_we;
  logic [AW-1:0]          w_clr_addr;
  logic                   w_ready;
  logic [NUM_RD*XLEN-1:0] w_rdata;
  logic [NUM_WR-1:0]      w_wr_ok;

  rv_regfile_clr_seq #(
    .NREGS (NREGS)
  ) u_clr_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_we_o   (w_clr_we),
    .clr_addr_o (w_clr_addr),
    .ready_o    (w_ready)
  );

  assign ready_o = w_ready;

  // A write port is live only in READY and never targets x0 when it is hardwired.
  always_comb begin
    w_wr_ok = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      w_wr_ok[p] = we_i[p] && w_ready &&
                   !((ZERO_R0 != 0) && (waddr_i[p*AW +: AW] == '0));
    end
  end

  // Later ports overwrite earlier ones in the loop, so the highest index wins.
  always_ff @(posedge clk_i) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (!rst_i) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_wr_ok[p]) r_mem[waddr_i[p*AW +: AW]] <= wdata_i[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      w_rdata[r*XLEN +: XLEN] = r_mem[raddr_i[r*AW +: AW]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (w_wr_ok[p] && (waddr_i[p*AW +: AW] == raddr_i[r*AW +: AW])) begin
            w_rdata[r*XLEN +: XLEN] = wdata_i[p*XLEN +: XLEN];
          end
        end
      end
      if (((ZERO_R0 != 0) && (raddr_i[r*AW +: AW] == '0)) || !w_ready) begin
        w_rdata[r*XLEN +: XLEN] = '0;
      end
    end
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [NUM_RD*XLEN-1:0] r_rdata;
    always_ff @(posedge clk_i) begin
      if (rst_i) r_rdata <= '0;
      else       r_rdata <= w_rdata;
    end
    assign rdata_o = r_rdata;
  end else begin : g_rd_comb
    assign rdata_o = w_rdata;
  end

endmodule
